// File: rtl/uncached_store_buffer_if.sv
// SRAM-like data bus between the core, the store buffer and the cache adapter.
// The master drives the request fields; the slave returns read data and handshakes.
interface uncached_store_buffer_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        uncached;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata, uncached,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata, uncached,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/uncached_store_buffer.sv
// Posted-write FIFO for uncached stores on the data-side SRAM-like bus; other accesses pass through once drained.
// Optional stall-cycle counter on sb_stall_cnt is built when SB_STALL_CNT_EN is defined.
module uncached_store_buffer #(
  parameter int DEPTH     = 4,
  parameter bit ENABLE_SB = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  uncached_store_buffer_if.slave cpu,
  uncached_store_buffer_if.master mem,
  output logic [31:0]            sb_stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN_WAIT,
    PASS_WAIT
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [31:0]    fifo_addr  [DEPTH];
  logic [31:0]    fifo_wdata [DEPTH];
  logic [1:0]     fifo_size  [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           ack_pend;

  logic           bufferable;
  logic           store_ok;
  logic           pass_ok;
  logic           push;
  logic           pop;

  assign bufferable = cpu.req & cpu.wr & cpu.uncached & ENABLE_SB;
  assign store_ok   = bufferable & (count < CW'(DEPTH)) & (state != PASS_WAIT);
  // A non-bufferable access only goes out once every posted store has drained.
  assign pass_ok    = (state == IDLE) & (count == '0) & cpu.req & ~bufferable & ~ack_pend;
  assign push       = ~rst & store_ok;
  assign pop        = (state == DRAIN_WAIT) & mem.data_ok;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr]  <= cpu.addr;
      fifo_wdata[wptr] <= cpu.wdata;
      fifo_size[wptr]  <= cpu.size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ack_pend <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      ack_pend <= push;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    mem.req      = 1'b0;
    mem.wr       = 1'b0;
    mem.size     = 2'd0;
    mem.addr     = 32'h0;
    mem.wdata    = 32'h0;
    mem.uncached = 1'b0;
    cpu.addr_ok  = 1'b0;
    cpu.data_ok  = 1'b0;
    cpu.rdata    = mem.rdata;
    if (!rst) begin
      cpu.addr_ok = store_ok;
      // Drain completions are absorbed here; only pass-through data_ok reaches the core.
      cpu.data_ok = ack_pend | ((state == PASS_WAIT) & mem.data_ok);
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            mem.req      = 1'b1;
            mem.wr       = 1'b1;
            mem.uncached = 1'b1;
            mem.size     = fifo_size[rptr];
            mem.addr     = fifo_addr[rptr];
            mem.wdata    = fifo_wdata[rptr];
            if (mem.addr_ok) next_state = DRAIN_WAIT;
          end else if (pass_ok) begin
            mem.req      = 1'b1;
            mem.wr       = cpu.wr;
            mem.uncached = cpu.uncached;
            mem.size     = cpu.size;
            mem.addr     = cpu.addr;
            mem.wdata    = cpu.wdata;
            cpu.addr_ok  = mem.addr_ok;
            if (mem.addr_ok) next_state = PASS_WAIT;
          end
        end
        DRAIN_WAIT: begin
          if (mem.data_ok) next_state = IDLE;
        end
        PASS_WAIT: begin
          if (mem.data_ok) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  pop_nonempty_a: assert property (@(posedge clk) disable iff (rst) !(pop && (count == '0)));

`ifdef SB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          sb_stall_cnt <= 32'h0;
    else if (cpu.req & ~cpu.addr_ok)  sb_stall_cnt <= sb_stall_cnt + 32'd1;
  end
`else
  assign sb_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Directed bench for uncached_store_buffer: a cycle table for single accesses plus
// hand-written sequences for fill/stall, push-with-pop, and reset during a drain.
module tb_uncached_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cnt;
  int          checks;
  int          failures;

  uncached_store_buffer_if cpu_if ();
  uncached_store_buffer_if mem_if ();

  uncached_store_buffer #(.DEPTH(4), .ENABLE_SB(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu_if),
    .mem          (mem_if),
    .sb_stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic        unc;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        m_aok;
    logic        m_dok;
    logic [31:0] m_rdata;
    logic        e_aok;
    logic        e_dok;
    logic        e_mreq;
    logic        e_mwr;
    logic [1:0]  e_msize;
    logic        e_munc;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        chk_rdata;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  logic [31:0] a2 [5];
  logic [31:0] d2 [5];
  logic [31:0] a5 [6];
  logic [31:0] d5 [6];
  logic [1:0]  s5 [6];
  logic [31:0] exp_stall;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and return at the falling edge.
  task automatic applyStimulus(input logic req, input logic wr, input logic unc,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic m_aok,
                               input logic m_dok, input logic [31:0] m_rdata);
    @(posedge clk);
    #1;
    cpu_if.req      = req;
    cpu_if.wr       = wr;
    cpu_if.uncached = unc;
    cpu_if.size     = size;
    cpu_if.addr     = addr;
    cpu_if.wdata    = wdata;
    mem_if.addr_ok  = m_aok;
    mem_if.data_ok  = m_dok;
    mem_if.rdata    = m_rdata;
    @(negedge clk);
  endtask

  task automatic applyReset();
    @(negedge clk);
    cpu_if.req     = 1'b0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkDrain(input string name, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size);
    checkOutput({name, ".mreq"},  mem_if.req, 1);
    checkOutput({name, ".mwr"},   mem_if.wr, 1);
    checkOutput({name, ".munc"},  mem_if.uncached, 1);
    checkOutput({name, ".maddr"}, mem_if.addr, addr);
    checkOutput({name, ".mdata"}, mem_if.wdata, wdata);
    checkOutput({name, ".msize"}, mem_if.size, size);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b0;
    cpu_if.req = 1'b1;  cpu_if.wr = 1'b0;  cpu_if.uncached = 1'b0;  cpu_if.size = 2'd2;
    cpu_if.addr = 32'h8000_0000;  cpu_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b1;  mem_if.data_ok = 1'b1;  mem_if.rdata = 32'h0;

    vecs[0]  = '{1,1,1,2,32'hBFAF0000,32'h00001234, 0,0,0, 1,0,0, 0,0,0,0,0, 0};
    vecs[1]  = '{0,0,0,0,0,0, 0,0,0, 0,1,1, 1,2,1,32'hBFAF0000,32'h00001234, 0};
    vecs[2]  = '{0,0,0,0,0,0, 1,0,0, 0,0,1, 1,2,1,32'hBFAF0000,32'h00001234, 0};
    vecs[3]  = '{0,0,0,0,0,0, 0,1,32'hDEAD0000, 0,0,0, 0,0,0,0,0, 0};
    vecs[4]  = '{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[5]  = '{1,1,1,2,32'hBFAF0010,32'hCAFEF00D, 0,0,0, 1,0,0, 0,0,0,0,0, 0};
    vecs[6]  = '{1,0,1,2,32'hBFAF0010,0, 1,0,0, 0,1,1, 1,2,1,32'hBFAF0010,32'hCAFEF00D, 0};
    vecs[7]  = '{1,0,1,2,32'hBFAF0010,0, 1,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[8]  = '{1,0,1,2,32'hBFAF0010,0, 1,1,32'h0BAD0BAD, 0,0,0, 0,0,0,0,0, 0};
    vecs[9]  = '{1,0,1,2,32'hBFAF0010,0, 1,0,0, 1,0,1, 0,2,1,32'hBFAF0010,0, 0};
    vecs[10] = '{0,0,0,0,0,0, 0,1,32'hCAFEF00D, 0,1,0, 0,0,0,0,0, 1};
    vecs[11] = '{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[12] = '{1,0,0,2,32'h80000100,0, 1,0,0, 1,0,1, 0,2,0,32'h80000100,0, 0};
    vecs[13] = '{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[14] = '{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[15] = '{0,0,0,0,0,0, 0,1,32'h5A5A1234, 0,1,0, 0,0,0,0,0, 1};
    vecs[16] = '{0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0};
    vecs[17] = '{1,1,0,0,32'h80000203,32'h000000AB, 0,0,0, 0,0,1, 1,0,0,32'h80000203,32'h000000AB, 0};
    vecs[18] = '{1,1,0,0,32'h80000203,32'h000000AB, 1,0,0, 1,0,1, 1,0,0,32'h80000203,32'h000000AB, 0};
    vecs[19] = '{0,0,0,0,0,0, 0,1,32'h00000011, 0,1,0, 0,0,0,0,0, 0};
    vecs[20] = '{0,0,0,0,0,0, 0,1,0, 0,0,0, 0,0,0,0,0, 0};

    for (int i = 0; i < 5; i++) begin
      a2[i] = 32'hBFAF0100 + 32'(i * 4);
      d2[i] = 32'hD2D20000 + 32'(i);
    end
    for (int i = 0; i < 6; i++) begin
      a5[i] = 32'hBFAF0200 + 32'(i * 4);
      d5[i] = 32'hE0E00000 + 32'(i);
      s5[i] = 2'(i % 3);
    end

    // Reset with a live-looking pass-through request on the inputs: everything must stay quiet.
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst.mreq",    mem_if.req, 0);
    checkOutput("rst.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("rst.data_ok", cpu_if.data_ok, 0);
    checkOutput("rst.stall",   stall_cnt, 0);
    cpu_if.req = 1'b0;  mem_if.addr_ok = 1'b0;  mem_if.data_ok = 1'b0;
    rst = 1'b0;

    $display("[TB] table: buffered store, store-then-load, cached pass-through");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].req, vecs[i].wr, vecs[i].unc, vecs[i].size, vecs[i].addr,
                    vecs[i].wdata, vecs[i].m_aok, vecs[i].m_dok, vecs[i].m_rdata);
      checkOutput($sformatf("v%0d.addr_ok", i), cpu_if.addr_ok, vecs[i].e_aok);
      checkOutput($sformatf("v%0d.data_ok", i), cpu_if.data_ok, vecs[i].e_dok);
      checkOutput($sformatf("v%0d.mreq", i),    mem_if.req,     vecs[i].e_mreq);
      if (vecs[i].e_mreq) begin
        checkOutput($sformatf("v%0d.mwr", i),   mem_if.wr,       vecs[i].e_mwr);
        checkOutput($sformatf("v%0d.msize", i), mem_if.size,     vecs[i].e_msize);
        checkOutput($sformatf("v%0d.munc", i),  mem_if.uncached, vecs[i].e_munc);
        checkOutput($sformatf("v%0d.maddr", i), mem_if.addr,     vecs[i].e_maddr);
        if (vecs[i].e_mwr)
          checkOutput($sformatf("v%0d.mdata", i), mem_if.wdata, vecs[i].e_mwdata);
      end
      if (vecs[i].chk_rdata)
        checkOutput($sformatf("v%0d.rdata", i), cpu_if.rdata, vecs[i].m_rdata);
    end

    $display("[TB] five back-to-back uncached stores into a depth-4 buffer");
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 2'd2, a2[i], d2[i], 0, 0, 0);
      checkOutput($sformatf("fill%0d.addr_ok", i), cpu_if.addr_ok, 1);
      if (i > 0) checkDrain($sformatf("fill%0d.head", i), a2[0], d2[0], 2'd2);
    end
    applyStimulus(1, 1, 1, 2'd2, a2[4], d2[4], 0, 0, 0);
    checkOutput("full.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("full.data_ok", cpu_if.data_ok, 1);
    checkDrain("full.head", a2[0], d2[0], 2'd2);
    applyStimulus(1, 1, 1, 2'd2, a2[4], d2[4], 1, 0, 0);
    checkOutput("full_acc.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("full_acc.data_ok", cpu_if.data_ok, 0);
    checkDrain("full_acc.head", a2[0], d2[0], 2'd2);
    applyStimulus(1, 1, 1, 2'd2, a2[4], d2[4], 0, 0, 0);
    checkOutput("full_wait.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("full_wait.mreq", mem_if.req, 0);
    applyStimulus(1, 1, 1, 2'd2, a2[4], d2[4], 0, 1, 0);
    checkOutput("full_pop.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("full_pop.data_ok", cpu_if.data_ok, 0);
    applyStimulus(1, 1, 1, 2'd2, a2[4], d2[4], 0, 0, 0);
    checkOutput("fifth.addr_ok", cpu_if.addr_ok, 1);
    checkDrain("fifth.head", a2[1], d2[1], 2'd2);
`ifdef SB_STALL_CNT_EN
    exp_stall = 32'd4;
`else
    exp_stall = 32'd0;
`endif
    checkOutput("fill.stall_cnt", stall_cnt, exp_stall);
    for (int j = 1; j < 5; j++) begin
      applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 0);
      checkDrain($sformatf("order%0d", j), a2[j], d2[j], 2'd2);
      checkOutput($sformatf("order%0d.data_ok", j), cpu_if.data_ok, (j == 1) ? 1 : 0);
      applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0);
      checkOutput($sformatf("order%0d.wait_mreq", j), mem_if.req, 0);
      checkOutput($sformatf("order%0d.data_ok_drain", j), cpu_if.data_ok, 0);
    end
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("fill.empty_mreq", mem_if.req, 0);

    $display("[TB] push with pop at count=DEPTH-1 across pointer wrap");
    applyStimulus(1, 1, 1, s5[0], a5[0], d5[0], 0, 0, 0);
    checkOutput("pp0.addr_ok", cpu_if.addr_ok, 1);
    applyStimulus(1, 1, 1, s5[1], a5[1], d5[1], 1, 0, 0);
    checkOutput("pp1.addr_ok", cpu_if.addr_ok, 1);
    checkDrain("pp1.head", a5[0], d5[0], s5[0]);
    applyStimulus(1, 1, 1, s5[2], a5[2], d5[2], 0, 0, 0);
    checkOutput("pp2.addr_ok", cpu_if.addr_ok, 1);
    checkOutput("pp2.mreq", mem_if.req, 0);
    applyStimulus(1, 1, 1, s5[3], a5[3], d5[3], 0, 1, 0);
    checkOutput("pp3.addr_ok", cpu_if.addr_ok, 1);
    checkOutput("pp3.data_ok", cpu_if.data_ok, 1);
    applyStimulus(1, 1, 1, s5[4], a5[4], d5[4], 1, 0, 0);
    checkOutput("pp4.addr_ok", cpu_if.addr_ok, 1);
    checkDrain("pp4.head", a5[1], d5[1], s5[1]);
    applyStimulus(1, 1, 1, s5[5], a5[5], d5[5], 0, 1, 0);
    checkOutput("pp5.full_addr_ok", cpu_if.addr_ok, 0);
    applyStimulus(1, 1, 1, s5[5], a5[5], d5[5], 1, 0, 0);
    checkOutput("pp6.addr_ok", cpu_if.addr_ok, 1);
    checkDrain("pp6.head", a5[2], d5[2], s5[2]);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0);
    checkOutput("pp7.mreq", mem_if.req, 0);
    checkOutput("pp7.data_ok", cpu_if.data_ok, 1);
    for (int j = 3; j < 6; j++) begin
      applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 0);
      checkDrain($sformatf("pporder%0d", j), a5[j], d5[j], s5[j]);
      applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0);
      checkOutput($sformatf("pporder%0d.wait_mreq", j), mem_if.req, 0);
    end
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("pp.empty_mreq", mem_if.req, 0);

    $display("[TB] reset asserted while a drain is outstanding");
    applyStimulus(1, 1, 1, 2'd2, 32'hBFAF0300, 32'hF0F00000, 0, 0, 0);
    checkOutput("rd0.addr_ok", cpu_if.addr_ok, 1);
    applyStimulus(1, 1, 1, 2'd2, 32'hBFAF0304, 32'hF0F00001, 1, 0, 0);
    checkDrain("rd1.head", 32'hBFAF0300, 32'hF0F00000, 2'd2);
    applyStimulus(1, 1, 1, 2'd2, 32'hBFAF0308, 32'hF0F00002, 1, 0, 0);
    checkOutput("rd2.addr_ok", cpu_if.addr_ok, 1);
    checkOutput("rd2.data_ok", cpu_if.data_ok, 1);
    rst = 1'b1;
    #1;
    checkOutput("rd_rst.mreq",    mem_if.req, 0);
    checkOutput("rd_rst.addr_ok", cpu_if.addr_ok, 0);
    checkOutput("rd_rst.data_ok", cpu_if.data_ok, 0);
    checkOutput("rd_rst.stall",   stall_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    cpu_if.req = 1'b0;  mem_if.addr_ok = 1'b0;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 0);
    checkOutput("post_rst.mreq", mem_if.req, 0);
    applyStimulus(1, 0, 0, 2'd2, 32'h80000400, 32'h0, 1, 0, 0);
    checkOutput("post_rst.addr_ok", cpu_if.addr_ok, 1);
    checkOutput("post_rst.pass_mreq", mem_if.req, 1);
    checkOutput("post_rst.pass_mwr", mem_if.wr, 0);
    checkOutput("post_rst.pass_maddr", mem_if.addr, 32'h80000400);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h600DF00D);
    checkOutput("post_rst.data_ok", cpu_if.data_ok, 1);
    checkOutput("post_rst.rdata", cpu_if.rdata, 32'h600DF00D);
    applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("post_rst.idle_data_ok", cpu_if.data_ok, 0);
    checkOutput("post_rst.idle_mreq", mem_if.req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
